// File: rtl/dmem_pkg.sv
// Shared types and helpers for the off-chip data-memory model.
// Line geometry and the responder FSM state encoding.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    localparam int OFFSET_BITS = 5;
    localparam int DEF_LINE_W  = 256;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_line_array.sv
// Single-port line storage: synchronous write, synchronous read.
// Storage has no reset; the read register only moves on a read access.
module dmem_line_array #(
    parameter int LINE_W = 256,
    parameter int DEPTH  = 512,
    parameter int IDX_W  = 9
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency line-fill / write-back responder for the data cache.
// Define DMEM_PROTOCOL_CHECK_EN to add the sticky proto_err_o checker.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int LINE_W  = DEF_LINE_W,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
`ifdef DMEM_PROTOCOL_CHECK_EN
    output logic              proto_err_o,
`endif
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_enable_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              mem_ack_o,
    output logic [LINE_W-1:0] mem_data_o
);

    localparam int IDX_W = idx_w(DEPTH);

    state_t            state;
    logic [7:0]        cnt;
    logic [IDX_W-1:0]  idx_q;
    logic              wr_q;
    logic [LINE_W-1:0] data_q;
    logic              rd_vld;
    logic [LINE_W-1:0] rd_data;
    logic              done;
    logic [ADDR_W-1:0] unused_addr;

    assign unused_addr = mem_addr_i;
    assign done = (state == BUSY) && (cnt == 8'd0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            data_q    <= '0;
            mem_ack_o <= 1'b0;
            rd_vld    <= 1'b0;
        end else begin
            mem_ack_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_enable_i) begin
                        idx_q  <= mem_addr_i[OFFSET_BITS +: IDX_W];
                        wr_q   <= mem_write_i;
                        data_q <= mem_data_i;
                        cnt    <= 8'(LATENCY - 1);
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 8'd0) begin
                        state     <= ACK;
                        mem_ack_o <= 1'b1;
                        if (!wr_q) rd_vld <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ACK: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read data is gated until the first read completes so reset shows zero.
    assign mem_data_o = rd_vld ? rd_data : '0;

    dmem_line_array #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_arr (
        .clk   (clk_i),
        .en    (done),
        .we    (wr_q),
        .addr  (idx_q),
        .wdata (data_q),
        .rdata (rd_data)
    );

`ifdef DMEM_PROTOCOL_CHECK_EN
    logic [ADDR_W-1:0] addr_q;
    logic              hi_nz;
    logic              busy_bad;

    assign hi_nz = (mem_addr_i >> (OFFSET_BITS + IDX_W)) != '0;
    assign busy_bad = !mem_enable_i || (mem_addr_i != addr_q) ||
                      (mem_write_i != wr_q) || (mem_data_i != data_q);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q      <= '0;
            proto_err_o <= 1'b0;
        end else begin
            if (state == IDLE && mem_enable_i) begin
                addr_q <= mem_addr_i;
                if (hi_nz) proto_err_o <= 1'b1;
            end
            if (state == BUSY && busy_bad) proto_err_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder.
// Reference model: line map indexed by (addr / 32) % DEPTH.
module tb_dmem_responder;

    localparam int LINE_W  = 256;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 512;
    localparam int LATENCY = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [LINE_W-1:0] wdata = '0;
    logic              ack;
    logic [LINE_W-1:0] dout;
`ifdef DMEM_PROTOCOL_CHECK_EN
    logic              perr;
`endif

    int errors = 0;
    int checks = 0;

    logic [LINE_W-1:0] mdl [int];
    logic [LINE_W-1:0] last_rd = '0;

    always #5 clk = ~clk;

    dmem_responder #(
        .LINE_W  (LINE_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
`ifdef DMEM_PROTOCOL_CHECK_EN
        .proto_err_o  (perr),
`endif
        .clk_i        (clk),
        .rst_i        (rst_n),
        .mem_enable_i (en),
        .mem_write_i  (we),
        .mem_addr_i   (addr),
        .mem_data_i   (wdata),
        .mem_ack_o    (ack),
        .mem_data_o   (dout)
    );

    task automatic chk(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int line_of(input logic [ADDR_W-1:0] a);
        return int'((a / 32) % DEPTH);
    endfunction

    // Waits for ack after an acceptance edge; returns edges counted.
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!ack && n < 300);
    endtask

    task automatic finish_ack(input bit wr, input logic [ADDR_W-1:0] a,
                              input logic [LINE_W-1:0] d);
        if (wr) begin
            chk("wr_dout_keep", dout, last_rd);
            mdl[line_of(a)] = d;
        end else begin
            last_rd = mdl[line_of(a)];
            chk("rd_data", dout, last_rd);
        end
    endtask

    task automatic run_req(input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [LINE_W-1:0] d, input bit keep);
        int n;
        @(negedge clk);
        en = 1'b1; we = wr; addr = a; wdata = d;
        @(posedge clk);
        wait_ack(n);
        chk("latency", LINE_W'(n), LINE_W'(LATENCY));
        finish_ack(wr, a, d);
        if (!keep) begin
            en = 1'b0;
            @(negedge clk);
            chk("ack_pulse", LINE_W'(ack), '0);
            chk("dout_hold", dout, last_rd);
        end
    endtask

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        int n;
        logic [LINE_W-1:0] a5;
        logic [LINE_W-1:0] v;
        logic [ADDR_W-1:0] ra;
        a5 = {32{8'hA5}};

        #12;
        chk("rst_ack", LINE_W'(ack), '0);
        chk("rst_dout", dout, '0);
`ifdef DMEM_PROTOCOL_CHECK_EN
        chk("rst_perr", LINE_W'(perr), '0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Read after preload
        run_req(1'b1, 32'h60, a5, 1'b0);
        run_req(1'b0, 32'h60, '0, 1'b0);
        chk("t1_a5", dout, a5);

        // Write then read
        run_req(1'b1, 32'h400, 256'h1234, 1'b0);
        run_req(1'b0, 32'h400, '0, 1'b0);
        chk("t2_1234", dout, 256'h1234);

        // Held enable: second acceptance only after one IDLE cycle
        run_req(1'b0, 32'h60, '0, 1'b1);
        wait_ack(n);
        chk("held_gap", LINE_W'(n), LINE_W'(LATENCY + 2));
        finish_ack(1'b0, 32'h60, '0);
        en = 1'b0;
        @(negedge clk);
        chk("held_pulse", LINE_W'(ack), '0);

        // Randomized traffic within the index range
        for (int i = 0; i < 16; i++) begin
            ra = ($urandom & 32'h0000_00FF) | (ADDR_W'($urandom_range(0, 3)) << 9);
            if (($urandom & 1) == 0 || !mdl.exists(line_of(ra)))
                run_req(1'b1, ra, rnd_line(), 1'b0);
            else
                run_req(1'b0, ra, '0, 1'b0);
        end

        // Reset mid-BUSY aborts the write
        v = rnd_line();
        run_req(1'b1, 32'h20, v, 1'b0);
        @(negedge clk);
        en = 1'b1; we = 1'b1; addr = 32'h20; wdata = 256'hFF;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ack", LINE_W'(ack), '0);
        chk("rst_mid_dout", dout, '0);
        en = 1'b0;
        last_rd = '0;
        repeat (15) begin
            @(negedge clk);
            if (ack) chk("rst_no_ack", LINE_W'(ack), '0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_dout", dout, '0);
        run_req(1'b0, 32'h20, '0, 1'b0);
        chk("rst_line_kept", dout, v);

`ifdef DMEM_PROTOCOL_CHECK_EN
        chk("perr_clean", LINE_W'(perr), '0);
        @(negedge clk);
        en = 1'b1; we = 1'b0; addr = 32'h60; wdata = '0;
        @(posedge clk);
        @(negedge clk);
        addr = 32'h400;
        @(negedge clk);
        chk("perr_set", LINE_W'(perr), 1);
        wait_ack(n);
        chk("perr_rd_capt", dout, mdl[line_of(32'h60)]);
        last_rd = dout;
        en = 1'b0;
        @(negedge clk);
        chk("perr_sticky", LINE_W'(perr), 1);
`endif

        // Index wrap modulo DEPTH
        v = rnd_line();
        run_req(1'b1, 32'h4020, v, 1'b0);
        run_req(1'b0, 32'h0020, '0, 1'b0);
        chk("wrap", dout, v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected done");
        $fatal(1, "timeout");
    end

endmodule
